serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor_if.sv | 24 ++
 rtl/serial_subtractor.sv | 122 ++++++++++++
 tb/tb_serial_subtractor.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// Handshake/operand bus for serial_subtractor: the requester drives start/a/b,
// and the subtractor returns its result and status flags.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             ovf;
  logic             busy;
  logic             done;

  modport master (
    output start, a, b,
    input  diff, borrow, ovf, busy, done
  );

  modport slave (
    input  start, a, b,
    output diff, borrow, ovf, busy, done
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b one bit per clock, LSB first, and
// publishes diff/borrow/ovf only once the whole word has been processed.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst,
  serial_subtractor_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             br_q, br_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;

  logic a_bit_s, b_bit_s, d_bit_s, br_next_s;

  // One full-subtractor cell operating on the current LSBs of the operand shifters
  always_comb begin
    a_bit_s   = a_sh_q[0];
    b_bit_s   = b_sh_q[0];
    d_bit_s   = a_bit_s ^ b_bit_s ^ br_q;
    br_next_s = (~a_bit_s & b_bit_s) | (~(a_bit_s ^ b_bit_s) & br_q);
  end

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    diff_d   = diff_q;
    br_d     = br_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
        res_sh_d = {d_bit_s, res_sh_q[WIDTH-1:1]};
        br_d     = br_next_s;
        if (cnt_q == LAST_BIT) begin
          // Operand shifters have delivered their MSBs, so the signed rule uses them directly
          state_d  = DONE;
          diff_d   = {d_bit_s, res_sh_q[WIDTH-1:1]};
          borrow_d = br_next_s;
          ovf_d    = (a_bit_s != b_bit_s) & (d_bit_s != a_bit_s);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      diff_q   <= '0;
      br_q     <= 1'b0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      diff_q   <= diff_d;
      br_q     <= br_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.diff   = diff_q;
  assign bus.borrow = borrow_q;
  assign bus.ovf    = ovf_q;
  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = (state_q == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random self-checking bench for serial_subtractor at WIDTH=8.
module tb_serial_subtractor;

  localparam int WIDTH = 8;
  localparam int MAX_WAIT = 40;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  serial_subtractor_if #(.WIDTH(WIDTH)) ifc ();

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stimulus only: pulses start with the given operands and watches until busy drops.
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                        output int busy_cnt, output int done_cnt, output int done_at,
                        output int partial, output int timeout);
    logic [7:0] held;
    int k;
    busy_cnt = 0; done_cnt = 0; done_at = 0; partial = 0; timeout = 1;
    @(negedge clk);
    ifc.a = av; ifc.b = bv; ifc.start = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
    held = ifc.diff;
    for (k = 1; k <= MAX_WAIT; k++) begin
      if (ifc.busy === 1'b1) busy_cnt++;
      if (ifc.done === 1'b1) begin
        done_cnt++;
        done_at = k;
      end else if (ifc.busy === 1'b1 && ifc.diff !== held) begin
        partial++;
      end
      if (ifc.busy !== 1'b1) begin
        timeout = 0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ifc.start = 1'b0; ifc.a = 8'h00; ifc.b = 8'h00;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({ifc.diff, ifc.borrow, ifc.ovf, ifc.busy, ifc.done} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_state: got diff=%h borrow=%b ovf=%b busy=%b done=%b, want all 0",
               ifc.diff, ifc.borrow, ifc.ovf, ifc.busy, ifc.done);
    end
    ifc.start = 1'b1; ifc.a = 8'h44; ifc.b = 8'h11;
    @(negedge clk);
    rst = 1'b0; ifc.start = 1'b0;
    repeat (2) begin
      n_checks++;
      if (ifc.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_beats_start: busy=%b, want 0", ifc.busy);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_directed();
    logic [7:0] va [6];
    logic [7:0] vb [6];
    logic [7:0] ed [6];
    logic       eb [6];
    logic       eo [6];
    int bc, dc, da, pc, to;
    va = '{8'h05, 8'h03, 8'h80, 8'h7F, 8'h00, 8'hFF};
    vb = '{8'h03, 8'h05, 8'h01, 8'hFF, 8'h00, 8'hFF};
    ed = '{8'h02, 8'hFE, 8'h7F, 8'h80, 8'h00, 8'h00};
    eb = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b0};
    eo = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0};
    for (int i = 0; i < 6; i++) begin
      run_op(va[i], vb[i], bc, dc, da, pc, to);
      n_checks++;
      if (to != 0) begin
        n_fail++;
        $display("FAIL dir%0d_timeout: busy still high after %0d cycles", i, MAX_WAIT);
      end
      n_checks++;
      if (bc != WIDTH + 1 || dc != 1 || da != WIDTH + 1) begin
        n_fail++;
        $display("FAIL dir%0d_timing: busy=%0d done_pulses=%0d done_at=%0d, want 9/1/9",
                 i, bc, dc, da);
      end
      n_checks++;
      if (pc != 0) begin
        n_fail++;
        $display("FAIL dir%0d_partial: diff changed %0d times while busy, want 0", i, pc);
      end
      n_checks++;
      if (ifc.diff !== ed[i] || ifc.borrow !== eb[i] || ifc.ovf !== eo[i]) begin
        n_fail++;
        $display("FAIL dir%0d_result %h-%h: got diff=%h borrow=%b ovf=%b, want %h %b %b",
                 i, va[i], vb[i], ifc.diff, ifc.borrow, ifc.ovf, ed[i], eb[i], eo[i]);
      end
    end
  endtask

  task automatic test_ignore_start();
    int dc;
    logic [7:0] dval;
    dc = 0; dval = 8'h00;
    @(negedge clk);
    ifc.a = 8'h10; ifc.b = 8'h01; ifc.start = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
    for (int k = 1; k <= MAX_WAIT; k++) begin
      if (k == 3) begin
        ifc.start = 1'b1; ifc.a = 8'hAA; ifc.b = 8'h55;
      end else if (k == 4) begin
        ifc.start = 1'b0;
      end
      if (ifc.done === 1'b1) begin
        dc++;
        dval = ifc.diff;
      end
      if (ifc.busy !== 1'b1) break;
      @(negedge clk);
    end
    repeat (4) begin
      @(negedge clk);
      if (ifc.done === 1'b1) dc++;
    end
    n_checks++;
    if (dc != 1) begin
      n_fail++;
      $display("FAIL ignore_start_pulses: done pulses=%0d, want 1", dc);
    end
    n_checks++;
    if (dval !== 8'h0F || ifc.diff !== 8'h0F) begin
      n_fail++;
      $display("FAIL ignore_start_diff: diff at done=%h now=%h, want 0f", dval, ifc.diff);
    end
  endtask

  task automatic test_reset_mid_run();
    int dc, bc, da, pc, to;
    dc = 0;
    @(negedge clk);
    ifc.a = 8'h33; ifc.b = 8'h11; ifc.start = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({ifc.diff, ifc.borrow, ifc.ovf, ifc.busy, ifc.done} !== 12'h000) begin
      n_fail++;
      $display("FAIL mid_run_reset: got diff=%h borrow=%b ovf=%b busy=%b done=%b, want all 0",
               ifc.diff, ifc.borrow, ifc.ovf, ifc.busy, ifc.done);
    end
    repeat (12) begin
      if (ifc.done === 1'b1 || ifc.busy === 1'b1) dc++;
      @(negedge clk);
    end
    n_checks++;
    if (dc != 0) begin
      n_fail++;
      $display("FAIL mid_run_no_done: busy/done seen %0d cycles after abort, want 0", dc);
    end
    run_op(8'h09, 8'h04, bc, dc, da, pc, to);
    n_checks++;
    if (to != 0 || dc != 1 || ifc.diff !== 8'h05 || ifc.borrow !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_op: diff=%h borrow=%b done_pulses=%0d timeout=%0d, want 05 0 1 0",
               ifc.diff, ifc.borrow, dc, to);
    end
  endtask

  task automatic test_back_to_back();
    int first_at, second_at, idle_cnt;
    logic [7:0] d1, d2;
    first_at = 0; second_at = 0; idle_cnt = 0; d1 = 8'h00; d2 = 8'h00;
    @(negedge clk);
    ifc.a = 8'h20; ifc.b = 8'h01; ifc.start = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= MAX_WAIT; k++) begin
      if (ifc.done === 1'b1) begin
        if (first_at == 0) begin
          first_at = k; d1 = ifc.diff;
          ifc.a = 8'h30; ifc.b = 8'h05;
        end else begin
          second_at = k; d2 = ifc.diff;
          ifc.start = 1'b0;
        end
      end
      if (ifc.busy !== 1'b1) idle_cnt++;
      if (second_at != 0) break;
      @(negedge clk);
    end
    @(negedge clk);
    n_checks++;
    if (first_at != 9 || second_at != 19 || idle_cnt != 1) begin
      n_fail++;
      $display("FAIL b2b_timing: done at %0d and %0d, idle cycles %0d, want 9, 19, 1",
               first_at, second_at, idle_cnt);
    end
    n_checks++;
    if (d1 !== 8'h1F || d2 !== 8'h2B) begin
      n_fail++;
      $display("FAIL b2b_results: got %h and %h, want 1f and 2b", d1, d2);
    end
  endtask

  task automatic test_random();
    int bc, dc, da, pc, to;
    logic [7:0] av, bv;
    logic [8:0] exp9;
    logic       exp_ovf;
    for (int i = 0; i < 1000; i++) begin
      av = 8'($urandom);
      bv = 8'($urandom);
      exp9 = {1'b0, av} - {1'b0, bv};
      exp_ovf = (av[7] != bv[7]) && (exp9[7] != av[7]);
      run_op(av, bv, bc, dc, da, pc, to);
      n_checks++;
      if (to != 0 || dc != 1 || {ifc.borrow, ifc.diff} !== exp9 || ifc.ovf !== exp_ovf) begin
        n_fail++;
        $display("FAIL rand%0d %h-%h: got borrow=%b diff=%h ovf=%b done=%0d, want %b %h %b 1",
                 i, av, bv, ifc.borrow, ifc.diff, ifc.ovf, dc, exp9[8], exp9[7:0], exp_ovf);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1'b1;
    ifc.start = 1'b0; ifc.a = 8'h00; ifc.b = 8'h00;
    test_reset();
    test_directed();
    test_ignore_start();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
